// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared StallBus definitions for the pipeline stall controller.
// Pattern constants list the stages that hold; the next stage down takes a bubble.
package pipe_stall_ctrl_pkg;

  localparam int STALL_BUS_W = 6;

  typedef logic [STALL_BUS_W-1:0] stall_bus_t;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  // Strict priority: MEM wait, then divider, then ID load-use.
  function automatic stall_bus_t stall_pattern(input logic mem_wait,
                                               input logic div_pending,
                                               input logic id_req);
    if (mem_wait)
      return STALL_MEM;
    else if (div_pending)
      return STALL_EX;
    else if (id_req)
      return STALL_ID;
    else
      return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_wait_timer.sv
// Stall wait timer: cycle counter with terminal-count compare and a sticky
// error flag, shared by any SRAM-wait watchdog.
module pipe_stall_ctrl_wait_timer #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic count,
  output logic at_limit,
  output logic err
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt;

  assign at_limit = (cnt == CW'(LIMIT - 1));

  // The counter parks at the terminal value; the next clear restarts it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (clear)
        cnt <= '0;
      else if (count && !at_limit)
        cnt <= cnt + CW'(1);
      if (count && at_limit)
        err <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall controller: arbitrates MEM wait, divider and ID
// load-use stalls onto the StallBus and counts stalled cycles.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int STALL_W     = 6,
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               stallreq_id,
  input  logic               ex_div_req,
  input  logic               div_ready,
  output logic               div_start,
  output logic               ex_div_done,
  input  logic               mem_req,
  input  logic               mem_ack,
  output logic [STALL_W-1:0] stall,
  output logic               err_timeout,
  output logic [CNT_W-1:0]   stall_cycles
);

  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_BUSY = 2'd1;
  localparam logic [1:0] D_DONE = 2'd2;

  localparam logic M_IDLE = 1'b0;
  localparam logic M_WAIT = 1'b1;

  logic [1:0] d_state, d_next;
  logic       m_state, m_next;
  logic       mem_wait;
  logic       div_pending;
  logic       tmr_clear, tmr_count, tmr_at_limit;
  stall_bus_t stall_bus;

  pipe_stall_ctrl_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_mem_timer (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (tmr_clear),
    .count    (tmr_count),
    .at_limit (tmr_at_limit),
    .err      (err_timeout)
  );

  always_comb begin
    d_next    = d_state;
    div_start = 1'b0;
    case (d_state)
      D_IDLE: begin
        if (ex_div_req) begin
          d_next    = D_BUSY;
          div_start = resetn;
        end
      end
      D_BUSY: begin
        if (div_ready)
          d_next = D_DONE;
      end
      D_DONE: begin
        // EX advances on the edge that leaves D_DONE, so wait out MEM stalls.
        if (!mem_wait)
          d_next = D_IDLE;
      end
      default: d_next = D_IDLE;
    endcase
  end

  always_comb begin
    m_next    = m_state;
    mem_wait  = 1'b0;
    tmr_clear = 1'b0;
    tmr_count = 1'b0;
    case (m_state)
      M_IDLE: begin
        if (mem_req && !mem_ack) begin
          m_next    = M_WAIT;
          mem_wait  = 1'b1;
          tmr_clear = 1'b1;
        end
      end
      M_WAIT: begin
        if (mem_ack) begin
          m_next = M_IDLE;
        end else begin
          tmr_count = 1'b1;
          if (tmr_at_limit)
            m_next = M_IDLE;
          else
            mem_wait = 1'b1;
        end
      end
      default: m_next = M_IDLE;
    endcase
  end

  assign ex_div_done = (d_state == D_DONE);
  assign div_pending = ex_div_req && (d_state != D_DONE);
  assign stall_bus   = resetn ? stall_pattern(mem_wait, div_pending, stallreq_id)
                              : STALL_NONE;
  assign stall       = STALL_W'(stall_bus);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      d_state <= D_IDLE;
      m_state <= M_IDLE;
    end else begin
      d_state <= d_next;
      m_state <= m_next;
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk) begin
    if (!resetn)
      stall_cycles <= '0;
    else if ((stall_bus[0] == STOP) && (stall_cycles != {CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed vector bench for pipe_stall_ctrl with a short MEM timeout and a
// narrow stall counter so timeout and saturation are reachable.
module tb_pipe_stall_ctrl;

  localparam int STALL_W     = 6;
  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_W       = 4;

  logic               clk;
  logic               resetn;
  logic               stallreq_id;
  logic               ex_div_req;
  logic               div_ready;
  logic               div_start;
  logic               ex_div_done;
  logic               mem_req;
  logic               mem_ack;
  logic [STALL_W-1:0] stall;
  logic               err_timeout;
  logic [CNT_W-1:0]   stall_cycles;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rn, id, dreq, drdy, mreq, mack;
    logic [5:0] stall;
    logic       start, done, err;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[17];

  pipe_stall_ctrl #(
    .STALL_W     (STALL_W),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .stallreq_id  (stallreq_id),
    .ex_div_req   (ex_div_req),
    .div_ready    (div_ready),
    .div_start    (div_start),
    .ex_div_done  (ex_div_done),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .stall        (stall),
    .err_timeout  (err_timeout),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic rn, input logic id, input logic dreq,
                                input logic drdy, input logic mreq, input logic mack);
    resetn      = rn;
    stallreq_id = id;
    ex_div_req  = dreq;
    div_ready   = drdy;
    mem_req     = mreq;
    mem_ack     = mack;
    #3;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [5:0] e_stall,
                           input logic e_start, input logic e_done,
                           input logic e_err, input logic [3:0] e_cnt);
    check_output({tag, " stall"},        32'(stall),        32'(e_stall));
    check_output({tag, " div_start"},    32'(div_start),    32'(e_start));
    check_output({tag, " ex_div_done"},  32'(ex_div_done),  32'(e_done));
    check_output({tag, " err_timeout"},  32'(err_timeout),  32'(e_err));
    check_output({tag, " stall_cycles"}, 32'(stall_cycles), 32'(e_cnt));
  endtask

  task automatic do_reset();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    next_cycle();
  endtask

  initial begin
    vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 6'b000000, 1'b0,1'b0,1'b0, 4'd0};
    vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 6'b000111, 1'b0,1'b0,1'b0, 4'd0};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 6'b000000, 1'b0,1'b0,1'b0, 4'd1};
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, 6'b000000, 1'b0,1'b0,1'b0, 4'd1};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 6'b011111, 1'b0,1'b0,1'b0, 4'd1};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 6'b011111, 1'b0,1'b0,1'b0, 4'd2};
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 6'b011111, 1'b0,1'b0,1'b0, 4'd3};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, 6'b000000, 1'b0,1'b0,1'b0, 4'd4};
    vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0, 6'b011111, 1'b0,1'b0,1'b0, 4'd4};
    vecs[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b1, 6'b000111, 1'b0,1'b0,1'b0, 4'd5};
    vecs[10] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 6'b001111, 1'b1,1'b0,1'b0, 4'd6};
    vecs[11] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 6'b001111, 1'b0,1'b0,1'b0, 4'd7};
    vecs[12] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 6'b001111, 1'b0,1'b0,1'b0, 4'd8};
    vecs[13] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 6'b000111, 1'b0,1'b1,1'b0, 4'd9};
    vecs[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 6'b000000, 1'b0,1'b0,1'b0, 4'd10};
    vecs[15] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 6'b000000, 1'b0,1'b0,1'b0, 4'd10};
    vecs[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 6'b000000, 1'b0,1'b0,1'b0, 4'd10};

    do_reset();

    // Mixed single-cycle vectors: load-use, MEM wait, priority, divide, stray ready.
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(vecs[i].rn, vecs[i].id, vecs[i].dreq,
                     vecs[i].drdy, vecs[i].mreq, vecs[i].mack);
      check_all($sformatf("vec%0d", i), vecs[i].stall, vecs[i].start,
                vecs[i].done, vecs[i].err, vecs[i].cnt);
      next_cycle();
    end

    // Long divide: ready at cycle 33, counter saturates at 15.
    do_reset();
    for (int c = 0; c < 34; c++) begin
      apply_stimulus(1, 0, 1, (c == 33), 0, 0);
      check_all($sformatf("div c%0d", c), 6'b001111, (c == 0), 1'b0, 1'b0,
                (c > 15) ? 4'd15 : 4'(c));
      next_cycle();
    end
    apply_stimulus(1, 0, 1, 0, 0, 0);
    check_all("div c34", 6'b000000, 1'b0, 1'b1, 1'b0, 4'd15);
    next_cycle();
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_all("div c35", 6'b000000, 1'b0, 1'b0, 1'b0, 4'd15);
    next_cycle();
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_all("div c36", 6'b000000, 1'b0, 1'b0, 1'b0, 4'd15);
    next_cycle();

    // Divider done while MEM stalls for four cycles.
    do_reset();
    apply_stimulus(1, 0, 1, 0, 0, 0);
    check_all("ovl c0", 6'b001111, 1'b1, 1'b0, 1'b0, 4'd0);
    next_cycle();
    apply_stimulus(1, 0, 1, 1, 0, 0);
    check_all("ovl c1", 6'b001111, 1'b0, 1'b0, 1'b0, 4'd1);
    next_cycle();
    for (int c = 2; c < 6; c++) begin
      apply_stimulus(1, 0, 1, 0, 1, 0);
      check_all($sformatf("ovl c%0d", c), 6'b011111, 1'b0, 1'b1, 1'b0, 4'(c));
      next_cycle();
    end
    apply_stimulus(1, 0, 1, 0, 1, 1);
    check_all("ovl c6", 6'b000000, 1'b0, 1'b1, 1'b0, 4'd6);
    next_cycle();
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_all("ovl c7", 6'b000000, 1'b0, 1'b0, 1'b0, 4'd6);
    next_cycle();

    // MEM timeout after eight stalled cycles; error sticks until reset.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      apply_stimulus(1, 0, 0, 0, 1, 0);
      check_all($sformatf("tmo c%0d", c), 6'b011111, 1'b0, 1'b0, 1'b0, 4'(c));
      next_cycle();
    end
    apply_stimulus(1, 0, 0, 0, 1, 0);
    check_all("tmo c8", 6'b000000, 1'b0, 1'b0, 1'b0, 4'd8);
    next_cycle();
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_all("tmo c9", 6'b000000, 1'b0, 1'b0, 1'b1, 4'd8);
    next_cycle();
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_all("tmo c10", 6'b000000, 1'b0, 1'b0, 1'b1, 4'd8);
    next_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_all("tmo c11", 6'b000000, 1'b0, 1'b0, 1'b1, 4'd8);
    next_cycle();
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_all("tmo c12", 6'b000000, 1'b0, 1'b0, 1'b0, 4'd0);
    next_cycle();

    // Reset while the divider is busy; a late ready is ignored.
    do_reset();
    apply_stimulus(1, 0, 1, 0, 0, 0);
    check_all("rst c0", 6'b001111, 1'b1, 1'b0, 1'b0, 4'd0);
    next_cycle();
    for (int c = 1; c < 3; c++) begin
      apply_stimulus(1, 0, 1, 0, 0, 0);
      check_all($sformatf("rst c%0d", c), 6'b001111, 1'b0, 1'b0, 1'b0, 4'(c));
      next_cycle();
    end
    apply_stimulus(0, 0, 1, 0, 0, 0);
    check_all("rst c3", 6'b000000, 1'b0, 1'b0, 1'b0, 4'd3);
    next_cycle();
    apply_stimulus(1, 0, 0, 1, 0, 0);
    check_all("rst c4", 6'b000000, 1'b0, 1'b0, 1'b0, 4'd0);
    next_cycle();
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_all("rst c5", 6'b000000, 1'b0, 1'b0, 1'b0, 4'd0);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall controller for the 5-stage pipeline. Produces the StallBus vector consumed by PC/IF/ID/EX/MEM/WB, including the pattern by which WB inserts a bubble.
- Arbitrates three stall sources: the ID load-use hazard, the EX multi-cycle divider, and the MEM data-SRAM wait.
- Sequences the divider start/done handshake, watches MEM waits with a timeout, and counts stalled cycles.

Parameters:
- STALL_W, 6: StallBus width. Bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.
- MEM_TIMEOUT, 256: maximum MEM wait cycles before the wait is abandoned.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk, in, 1: single clock.
- resetn, in, 1: reset, synchronous, active-low.
- stallreq_id, in, 1: load-use hazard request from ID (level, combinational).
- ex_div_req, in, 1: EX holds a div/divu not yet completed (level).
- div_ready, in, 1: divider result valid (1-cycle pulse).
- div_start, out, 1: divider start (1-cycle pulse).
- ex_div_done, out, 1: EX may capture the quotient/remainder and advance.
- mem_req, in, 1: MEM holds a load/store awaiting the data SRAM (level).
- mem_ack, in, 1: data SRAM completion (1-cycle pulse).
- stall, out, STALL_W: StallBus. 1 = Stop.
- err_timeout, out, 1: sticky MEM-timeout flag.
- stall_cycles, out, CNT_W: saturating count of cycles with stall[0] = 1.

Behaviour:
Reset (resetn = 0 at a clk edge):
- Both FSMs go to idle.
- div_start = 0, ex_div_done = 0, err_timeout = 0, stall_cycles = 0, timeout counter = 0.
- stall = 0 while in reset.
- A reset in mid-operation abandons any divider or MEM wait with no further outputs.

Divider FSM (D_IDLE, D_BUSY, D_DONE):
- D_IDLE: if ex_div_req = 1, go to D_BUSY and assert div_start combinationally in that same cycle (exactly one cycle).
- D_BUSY: stay until div_ready = 1, then go to D_DONE.
- D_DONE: ex_div_done = 1. Return to D_IDLE on the first cycle with mem_wait = 0; the EX instruction advances on that edge. While mem_wait = 1, hold D_DONE and keep ex_div_done = 1.
- A div_ready pulse arriving in D_IDLE is ignored.
- div_pending = ex_div_req AND state != D_DONE.

MEM wait FSM (M_IDLE, M_WAIT):
- M_IDLE: if mem_req = 1 and mem_ack = 0, go to M_WAIT and clear the timeout counter.
- M_WAIT: on mem_ack = 1, go to M_IDLE.
- M_WAIT: otherwise increment the counter. When the counter reaches MEM_TIMEOUT-1, go to M_IDLE and set err_timeout = 1 (cleared only by reset).
- mem_wait = (M_IDLE AND mem_req AND NOT mem_ack) OR (M_WAIT AND NOT mem_ack AND counter != MEM_TIMEOUT-1).
- An ack in the same cycle as the request causes no stall.

Stall priority (combinational from state and inputs, zero latency):
- mem_wait: stall = 6'b011111. WB receives a bubble.
- else div_pending: stall = 6'b001111. MEM receives a bubble.
- else stallreq_id: stall = 6'b000111. EX receives a bubble.
- else stall = 6'b000000.
- Simultaneous sources resolve strictly by this priority. Lower-priority sources are not lost because they are level requests and are re-evaluated every cycle.

stall_cycles:
- Registered; increments on each clock edge where stall[0] = 1.
- Saturates at all-ones and does not wrap.

Decomposition:
- defines.vh gains StallBus (6), Stop/NoStop and the four stall pattern constants: STALL_NONE, STALL_ID, STALL_EX, STALL_MEM.
- Divider and MEM FSM state encodings stay local parameters.
- One sub-module is natural: stall_wait_timer (counter, terminal-count compare, sticky error), reusable for a future instruction-SRAM wait.

Test Plan:
1. Load-use: stallreq_id = 1 for one cycle, nothing else active -> stall = 000111 for exactly that cycle, then 000000; stall_cycles = 1.
2. Divide: ex_div_req rises at cycle 0, div_ready pulses at cycle 33 -> div_start = 1 only at cycle 0; stall = 001111 for cycles 0..33; cycle 34 stall = 000000 and ex_div_done = 1; then D_IDLE.
3. MEM wait: mem_req held, mem_ack at cycle 3 -> stall = 011111 for cycles 0..2; cycle 3 stall = 000000.
4. Overlap: divider in D_DONE while mem_wait lasts 4 cycles -> stall = 011111 and ex_div_done held high for 4 cycles; D_IDLE entered on the cycle after mem_wait drops.
5. Timeout with MEM_TIMEOUT = 8: mem_req held, no ack -> stall = 011111 for 8 cycles, then err_timeout = 1 and it stays high until resetn = 0.
6. Reset mid-divide: resetn = 0 during D_BUSY -> next edge: stall = 0, stall_cycles = 0, no ex_div_done. A div_ready arriving afterwards is ignored.
